oddr_serial_tx: RTL

Output-side dual-data-rate serializer, the transmit counterpart to the dual-data-rate input flip-flop pair. It accepts parallel words over a valid/ready handshake and buffers one word. It then drives two bits per clock on a single pin, LSB first: the even bit during the C-high phase and the odd bit during the C-low phase. It sits at the pad boundary of the lab I/O path and feeds the input DDR capture block on the far end.

---
 rtl/oddr_serial_tx_pkg.sv | 19 +
 rtl/oddr_serial_tx_out.sv | 21 ++
 rtl/oddr_serial_tx.sv | 127 ++++++++++++
 3 files changed

// File: rtl/oddr_serial_tx_pkg.sv
// Shared types and sizing helpers for the DDR output serializer.
package oddr_serial_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int WIDTH_DEFAULT = 8;
    localparam int BEATS         = WIDTH_DEFAULT / 2;

    // Beat counter width for a given word width, never narrower than one bit.
    function automatic int cnt_width(input int width);
        int beats;
        beats = width / 2;
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/oddr_serial_tx_out.sv
// DDR pin cell: Q1 is retimed on the falling edge so O is a clean mux by C.
module oddr_out_cell #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic C,
    input  logic CLR_N,
    input  logic Q0,
    input  logic Q1,
    output logic O
);

    logic r_q1_neg;

    always_ff @(negedge C or negedge CLR_N) begin
        if (!CLR_N) r_q1_neg <= IDLE_LEVEL;
        else        r_q1_neg <= Q1;
    end

    assign O = C ? Q0 : r_q1_neg;

endmodule

// File: rtl/oddr_serial_tx.sv
// Parallel-in DDR serializer: one-word holding register, 2-bit-per-beat shifter, pin cell.
//
// state | meaning
// IDLE  | no word on Q0/Q1, waiting for the holding register to fill
// SHIFT | a beat of the current word is on Q0/Q1
module oddr_serial_tx
    import oddr_serial_tx_pkg::*;
#(
    parameter int   WIDTH      = WIDTH_DEFAULT,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             C,
    input  logic             CLR_N,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    input  logic             DIN_VALID,
    output logic             DIN_READY,
    output logic             Q0,
    output logic             Q1,
    output logic             O,
    output logic             FRAME,
    output logic             BUSY
);

    localparam int            N_BEATS = WIDTH / 2;
    localparam int            CW      = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(N_BEATS - 1);

    logic [WIDTH-1:0] r_h;
    logic             r_h_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_cnt;
    state_e           r_state;
    logic             r_q0;
    logic             r_q1;
    logic             r_frame;

    logic w_accept;
    logic w_last;
    logic w_load;

    assign w_accept = CE & DIN_VALID & r_ready;
    assign w_last   = (r_cnt == LAST);
    assign w_load   = CE & r_h_full & ((r_state == IDLE) | w_last);

    // Ready never overlaps a full H, so accept and drain are exclusive.
    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            r_h      <= '0;
            r_h_full <= 1'b0;
            r_ready  <= 1'b0;
        end else if (CE) begin
            if (w_accept) begin
                r_h      <= DIN;
                r_h_full <= 1'b1;
                r_ready  <= 1'b0;
            end else if (w_load) begin
                r_h_full <= 1'b0;
                r_ready  <= 1'b1;
            end else begin
                r_ready  <= ~r_h_full;
            end
        end
    end

    always_ff @(posedge C or negedge CLR_N) begin
        if (!CLR_N) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_cnt   <= '0;
            r_q0    <= IDLE_LEVEL;
            r_q1    <= IDLE_LEVEL;
            r_frame <= 1'b0;
        end else if (CE) begin
            case (r_state)
                IDLE: begin
                    if (r_h_full) begin
                        r_s     <= r_h >> 2;
                        r_q0    <= r_h[0];
                        r_q1    <= r_h[1];
                        r_cnt   <= '0;
                        r_frame <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_last && r_h_full) begin
                        r_s     <= r_h >> 2;
                        r_q0    <= r_h[0];
                        r_q1    <= r_h[1];
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_q0    <= IDLE_LEVEL;
                        r_q1    <= IDLE_LEVEL;
                        r_cnt   <= '0;
                        r_frame <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_s     <= r_s >> 2;
                        r_q0    <= r_s[0];
                        r_q1    <= r_s[1];
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign DIN_READY = r_ready;
    assign Q0        = r_q0;
    assign Q1        = r_q1;
    assign FRAME     = r_frame;
    assign BUSY      = r_frame | r_h_full;

    oddr_out_cell #(
        .IDLE_LEVEL (IDLE_LEVEL)
    ) u_out (
        .C     (C),
        .CLR_N (CLR_N),
        .Q0    (r_q0),
        .Q1    (r_q1),
        .O     (O)
    );

endmodule
